cache_mem_responder: RTL and testbench
======================================

# cache_mem_responder

Backing-memory responder for the two-way write-through data cache. It services the cache's block-read misses, returning a 4-word, 128-bit block after a fixed latency, and its single-word write-through stores. It sits between the cache's miss/write-through interface and the simulated main-memory array, and models DRAM latency for the Lab 2 memory hierarchy.

## Interface
- WORDS, 4096: backing store depth in 32-bit words; power of two, ≥ 4.
- LATENCY, 4: cycles from request acceptance to completion; ≥ 1.
- Clk  in  1  clock; all state changes on rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- readmiss  in  1  block-read request level from the cache.
- memwritethru  in  1  write-through request level from the cache.
- addymem  in  32  byte address; word index = addymem[31:2] mod WORDS; block base = index with bits [1:0] cleared.
- datawrite  in  32  write-through data.
- datareadmiss  out  128  returned block {word3, word2, word1, word0}; word0 is at the block base.
- readready  out  1  one-cycle pulse; datareadmiss valid in that cycle and held until the next read completes.
- writedone  out  1  one-cycle pulse when a write commits to the array.
- busy  out  1  high while a transaction is active or pending.

## Operation
- Requests are edge-triggered. A registered copy of each request line is kept, and a request is recognised when the line is 1 and its registered copy is 0. A level held high after service never re-triggers.
- On recognition, the responder latches a pending flag and the request's address. For writes it also latches datawrite. There is one pending slot per type. A new edge on an already-pending type overwrites that slot's address and data.
- FSM states:
  - IDLE → W_BUSY if a write is pending; else → R_BUSY if a read is pending.
  - W_BUSY: the counter runs LATENCY cycles. On expiry, mem[idx] ← data, writedone pulses, and the pending flag clears. Then → R_BUSY if a read is pending, else → IDLE.
  - R_BUSY: the counter runs LATENCY cycles. On expiry, datareadmiss ← mem[base+3..base], readready pulses, and the pending flag clears. Then → W_BUSY if a write is pending, else → IDLE.
- Write has priority when both are pending at the same decision point. A simultaneous readmiss and memwritethru edge (the cache's write-miss) therefore commits the word first, and the returned block contains the new word.
- The read array access happens at the expiry edge, so it sees any write committed at or before that edge.
- Addresses beyond WORDS*4 bytes alias modulo WORDS.
- The memory array is not cleared by reset; it is initialised to zero at time 0 for simulation.

## Timing
- Reset values: datareadmiss = 0, readready = 0, writedone = 0, busy = 0, state IDLE, counter 0, pending flags 0, registered request copies 0.
- Reset mid-transaction aborts it. An uncommitted write is dropped and no pulse is issued. A request line still high after Rst falls is seen as a new edge on the first Clk edge.
- Request edge sampled at posedge N with the FSM in IDLE:
  - busy = 1 from posedge N.
  - Completion at posedge N+LATENCY; the readready/writedone pulse is high from N+LATENCY to N+LATENCY+1.
- Chained transactions start at the previous transaction's expiry edge, with no idle cycle. A combined write+read therefore gives writedone at N+L and readready at N+2L.
- busy falls at the expiry edge when nothing remains pending.
- A request edge arriving at the same posedge as an expiry is latched. It is serviced immediately if its type is next in priority order.
- Counter width is clog2(LATENCY+1). LATENCY = 1 gives completion at the edge after acceptance.

## Test plan
- Reset, then write 0xDEADBEEF to 0x00000104 (edge at N) → writedone pulse at N+4; busy = 0 after N+4; no readready.
- Preload words 0x100..0x10C = 0x11, 0x22, 0x33, 0x44, then readmiss at 0x00000108 → readready at N+4, datareadmiss = 0x00000044_00000033_00000022_00000011.
- Same-edge memwritethru (0xCAFEF00D at 0x0000010C) and readmiss (0x0000010C) → writedone at N+4, readready at N+8, datareadmiss[127:96] = 0xCAFEF00D.
- Hold readmiss high for 20 cycles after a single read → exactly one readready pulse; busy = 0 after N+4.
- Assert Rst at N+2 of a write to 0x200 → no writedone, all outputs 0, and mem[0x200>>2] unchanged. A readmiss edge after reset completes normally 4 cycles after its edge.
- Write 0x5A5A5A5A to address WORDS*4+0x10 → a read of block 0x10 returns 0x5A5A5A5A in word0 (alias).

Source files
------------

// File: rtl/cache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_responder
// Description : Backing-memory responder for the two-way write-through data
//               cache. Serves 4-word block reads on a cache miss and
//               single-word write-through stores. Each transaction completes
//               a fixed LATENCY cycles after it is accepted, which models
//               DRAM latency.
// Ports       : Clk, Rst      - clock and asynchronous active-high reset
//               readmiss      - block-read request level (edge-triggered)
//               memwritethru  - write-through request level (edge-triggered)
//               addymem       - byte address, word index = addymem[31:2]
//               datawrite     - write-through data word
//               datareadmiss  - returned block {word3,word2,word1,word0}
//               readready     - one-cycle pulse when a block read completes
//               writedone     - one-cycle pulse when a write commits
//               busy          - a transaction is active or pending
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_responder #(
   parameter int WORDS   = 4096,
   parameter int LATENCY = 4
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         readmiss,
   input  logic         memwritethru,
   input  logic [31:0]  addymem,
   input  logic [31:0]  datawrite,
   output logic [127:0] datareadmiss,
   output logic         readready,
   output logic         writedone,
   output logic         busy
);

   localparam int IDX_W = $clog2(WORDS);
   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(LATENCY - 1);
   localparam logic [IDX_W-1:0] c_base_mask = ~IDX_W'(3);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_W_BUSY = 2'd1,
      ST_R_BUSY = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_rm_q;
   logic             r_wt_q;
   logic             r_rd_pend;
   logic             r_wr_pend;
   logic [IDX_W-1:0] r_rd_idx;
   logic [IDX_W-1:0] r_wr_idx;
   logic [31:0]      r_wr_data;

   // Not touched by reset; starts at zero for simulation.
   logic [31:0] r_mem [WORDS] = '{default: '0};

   logic             w_rm_edge;
   logic             w_wt_edge;
   logic             w_expire;
   logic             w_wr_commit;
   logic             w_rd_commit;
   logic             w_wr_pend_nxt;
   logic             w_rd_pend_nxt;
   logic [IDX_W-1:0] w_rd_base;
   logic             w_unused;

   assign w_rm_edge   = readmiss & ~r_rm_q;
   assign w_wt_edge   = memwritethru & ~r_wt_q;
   assign w_expire    = (r_state != ST_IDLE) && (r_cnt == c_cnt_last);
   assign w_wr_commit = (r_state == ST_W_BUSY) && w_expire;
   assign w_rd_commit = (r_state == ST_R_BUSY) && w_expire;

   // A fresh edge wins over the clear at expiry so a request arriving on the
   // completion edge is never lost.
   assign w_wr_pend_nxt = w_wt_edge | (r_wr_pend & ~w_wr_commit);
   assign w_rd_pend_nxt = w_rm_edge | (r_rd_pend & ~w_rd_commit);

   assign w_rd_base = r_rd_idx & c_base_mask;

   // Address bits outside the aliased word index are intentionally ignored.
   assign w_unused = ^{addymem[31:IDX_W+2], addymem[1:0]};

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_rm_q       <= 1'b0;
         r_wt_q       <= 1'b0;
         r_rd_pend    <= 1'b0;
         r_wr_pend    <= 1'b0;
         r_rd_idx     <= '0;
         r_wr_idx     <= '0;
         r_wr_data    <= '0;
         datareadmiss <= '0;
         readready    <= 1'b0;
         writedone    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         r_rm_q    <= readmiss;
         r_wt_q    <= memwritethru;
         r_wr_pend <= w_wr_pend_nxt;
         r_rd_pend <= w_rd_pend_nxt;
         readready <= w_rd_commit;
         writedone <= w_wr_commit;
         busy      <= w_wr_pend_nxt | w_rd_pend_nxt;

         if (w_wt_edge) begin
            r_wr_idx  <= addymem[IDX_W+1:2];
            r_wr_data <= datawrite;
         end
         if (w_rm_edge) begin
            r_rd_idx <= addymem[IDX_W+1:2];
         end

         // Writes and reads never expire on the same edge, so this always
         // observes every previously committed write.
         if (w_rd_commit) begin
            datareadmiss <= {r_mem[w_rd_base | IDX_W'(3)],
                             r_mem[w_rd_base | IDX_W'(2)],
                             r_mem[w_rd_base | IDX_W'(1)],
                             r_mem[w_rd_base]};
         end

         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (r_wr_pend | w_wt_edge) begin
                  r_state <= ST_W_BUSY;
               end else if (r_rd_pend | w_rm_edge) begin
                  r_state <= ST_R_BUSY;
               end
            end
            ST_W_BUSY: begin
               if (w_expire) begin
                  r_cnt   <= '0;
                  r_state <= (r_rd_pend | w_rm_edge) ? ST_R_BUSY : ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_R_BUSY: begin
               if (w_expire) begin
                  r_cnt   <= '0;
                  r_state <= (r_wr_pend | w_wt_edge) ? ST_W_BUSY : ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_cnt   <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (w_wr_commit) begin
         r_mem[r_wr_idx] <= r_wr_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_responder
// Description : Scoreboard bench for cache_mem_responder. The stimulus
//               process queues expected pulses and busy/reset states; a
//               monitor on the falling clock edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_responder;

   localparam int WORDS = 4096;
   localparam int LAT   = 4;

   logic         Clk = 1'b0;
   logic         Rst;
   logic         readmiss;
   logic         memwritethru;
   logic [31:0]  addymem;
   logic [31:0]  datawrite;
   logic [127:0] datareadmiss;
   logic         readready;
   logic         writedone;
   logic         busy;

   cache_mem_responder #(.WORDS(WORDS), .LATENCY(LAT)) dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .readmiss     (readmiss),
      .memwritethru (memwritethru),
      .addymem      (addymem),
      .datawrite    (datawrite),
      .datareadmiss (datareadmiss),
      .readready    (readready),
      .writedone    (writedone),
      .busy         (busy)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      bit           rd;
      int           cyc;
      logic [127:0] data;
   } pulse_t;

   typedef struct {
      int cyc;
      bit zero;
      bit bsy;
   } stat_t;

   pulse_t pq[$];
   stat_t  sq[$];
   int     n_assert = 0;
   int     n_fail   = 0;
   int     cyc      = 0;
   bit     done     = 1'b0;

   always @(posedge Clk) cyc <= cyc + 1;

   // Monitor: every comparison is made here.
   always @(negedge Clk) begin
      pulse_t p;
      stat_t  s;
      while (pq.size() > 0 && pq[0].cyc < cyc) begin
         p = pq.pop_front();
         n_assert++;
         n_fail++;
         $display("FAIL missing_pulse: no %s pulse seen, required at cycle %0d",
                  p.rd ? "readready" : "writedone", p.cyc);
      end
      if (readready || writedone) begin
         n_assert++;
         if (pq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: cycle %0d readready=%b writedone=%b, required none",
                     cyc, readready, writedone);
         end else begin
            p = pq.pop_front();
            if (p.rd != readready || p.rd == writedone || p.cyc != cyc ||
                (p.rd && datareadmiss !== p.data)) begin
               n_fail++;
               $display("FAIL %s_pulse: got cyc=%0d rr=%b wd=%b data=%h, required cyc=%0d data=%h",
                        p.rd ? "read" : "write", cyc, readready, writedone,
                        datareadmiss, p.cyc, p.data);
            end
         end
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
         s = sq.pop_front();
         n_assert++;
         if (s.zero) begin
            if (datareadmiss !== '0 || readready !== 1'b0 ||
                writedone !== 1'b0 || busy !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_outputs: cyc=%0d data=%h rr=%b wd=%b busy=%b, required all 0",
                        cyc, datareadmiss, readready, writedone, busy);
            end
         end else if (busy !== s.bsy) begin
            n_fail++;
            $display("FAIL busy: cyc=%0d got %b, required %b", cyc, busy, s.bsy);
         end
      end
      if (done) begin
         n_assert++;
         if (pq.size() != 0 || sq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d pulses and %0d states outstanding, required 0",
                     pq.size(), sq.size());
         end
         $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
         $finish;
      end
   end

   // Issue a request with the line(s) held for 'hold' cycles and queue the
   // expected pulse(s) and busy profile. Edge is sampled at posedge n.
   task automatic issue(input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input int hold,
                        input logic [127:0] exp_blk);
      int n;
      int t;
      int last;
      @(negedge Clk);
      memwritethru = w;
      readmiss     = r;
      addymem      = a;
      datawrite    = d;
      n = cyc + 1;
      t = (w && r) ? 2 * LAT : LAT;
      if (w) pq.push_back('{rd: 1'b0, cyc: n + LAT, data: '0});
      if (r) pq.push_back('{rd: 1'b1, cyc: n + t, data: exp_blk});
      for (int k = 0; k < t; k++) sq.push_back('{cyc: n + k, zero: 1'b0, bsy: 1'b1});
      last = (hold > t) ? hold : t;
      for (int k = t; k <= last; k++) sq.push_back('{cyc: n + k, zero: 1'b0, bsy: 1'b0});
      repeat (hold) @(negedge Clk);
      memwritethru = 1'b0;
      readmiss     = 1'b0;
      while (cyc < n + last + 1) @(negedge Clk);
   endtask

   initial begin
      int n;
      Rst          = 1'b1;
      readmiss     = 1'b0;
      memwritethru = 1'b0;
      addymem      = '0;
      datawrite    = '0;
      sq.push_back('{cyc: 1, zero: 1'b1, bsy: 1'b0});
      sq.push_back('{cyc: 2, zero: 1'b1, bsy: 1'b0});
      repeat (3) @(negedge Clk);
      Rst = 1'b0;

      // Single write, then preload a block and read it from a mid-block address.
      issue(1'b1, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 1, '0);
      issue(1'b1, 1'b0, 32'h0000_0100, 32'h0000_0011, 1, '0);
      issue(1'b1, 1'b0, 32'h0000_0104, 32'h0000_0022, 1, '0);
      issue(1'b1, 1'b0, 32'h0000_0108, 32'h0000_0033, 1, '0);
      issue(1'b1, 1'b0, 32'h0000_010C, 32'h0000_0044, 1, '0);
      issue(1'b0, 1'b1, 32'h0000_0108, '0, 1,
            128'h00000044_00000033_00000022_00000011);

      // Write-miss: same-edge write and read, write commits first.
      issue(1'b1, 1'b1, 32'h0000_010C, 32'hCAFE_F00D, 1,
            128'hCAFEF00D_00000033_00000022_00000011);

      // Level held for 20 cycles must produce exactly one read.
      issue(1'b0, 1'b1, 32'h0000_0100, '0, 20,
            128'hCAFEF00D_00000033_00000022_00000011);

      // Reset two cycles into a write to 0x200: the write is dropped.
      @(negedge Clk);
      memwritethru = 1'b1;
      addymem      = 32'h0000_0200;
      datawrite    = 32'h1234_5678;
      n = cyc + 1;
      sq.push_back('{cyc: n,     zero: 1'b0, bsy: 1'b1});
      sq.push_back('{cyc: n + 1, zero: 1'b0, bsy: 1'b1});
      sq.push_back('{cyc: n + 2, zero: 1'b1, bsy: 1'b0});
      sq.push_back('{cyc: n + 3, zero: 1'b1, bsy: 1'b0});
      @(negedge Clk);
      memwritethru = 1'b0;
      @(negedge Clk);
      @(posedge Clk);
      #2 Rst = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      #1 Rst = 1'b0;
      issue(1'b0, 1'b1, 32'h0000_0200, '0, 1, '0);

      // Address beyond the array aliases back onto word 4.
      issue(1'b1, 1'b0, 32'(WORDS * 4 + 'h10), 32'h5A5A_5A5A, 1, '0);
      issue(1'b0, 1'b1, 32'h0000_0010, '0, 1,
            128'h00000000_00000000_00000000_5A5A5A5A);

      done = 1'b1;
      repeat (5) @(negedge Clk);
      $display("FAIL monitor_stall: summary not reached, required within 5 cycles");
      $fatal(1);
   end

endmodule
`default_nettype wire
